// File: rtl/sdram_bus_arbiter_pkg.sv
// sdram_bus_arbiter_pkg: shared widths, master ids and lock state encoding
package sdram_bus_arbiter_pkg;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;
  localparam int CTX_W = 8;
  localparam int MAX_PEND = 4;
  localparam int SRC_BIT = CTX_W - 1;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  typedef enum logic {IDLE, LOCKED} lock_state_t;
endpackage

// File: rtl/sdram_bus_pending_counter.sv
// sdram_bus_pending_counter: in-flight command count with sticky underflow flag
module sdram_bus_pending_counter #(
  parameter int MAX_PENDING = 4,
  parameter int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [PW-1:0] count,
  output logic          at_limit,
  output logic          underflow
);
  logic [PW-1:0] count_q, count_d;
  logic underflow_q, underflow_d;
  always_comb begin
    count_d = (inc && !dec) ? count_q + PW'(1) :
              (dec && !inc && count_q != '0) ? count_q - PW'(1) : count_q;
    underflow_d = underflow_q || (dec && count_q == '0);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      underflow_q <= underflow_d;
    end
  end
  assign count = count_q;
  assign at_limit = count_q >= PW'(MAX_PENDING);
  assign underflow = underflow_q;
endmodule

// File: rtl/sdram_bus_arbiter.sv
// sdram_bus_arbiter: two-master round-robin arbiter onto one SdramCtrl bus,
// grant held while a command is stalled, responses routed by context MSB
module sdram_bus_arbiter
  import sdram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int CTX_WIDTH = CTX_W,
  parameter int MAX_PENDING = MAX_PEND,
  parameter int PW = $clog2(MAX_PENDING + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    io_m0_cmd_valid,
  output logic                    io_m0_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   io_m0_cmd_payload_address,
  input  logic                    io_m0_cmd_payload_write,
  input  logic [DATA_WIDTH-1:0]   io_m0_cmd_payload_data,
  input  logic [DATA_WIDTH/8-1:0] io_m0_cmd_payload_mask,
  input  logic [CTX_WIDTH-2:0]    io_m0_cmd_payload_context,
  output logic                    io_m0_rsp_valid,
  input  logic                    io_m0_rsp_ready,
  output logic [DATA_WIDTH-1:0]   io_m0_rsp_payload_data,
  output logic [CTX_WIDTH-2:0]    io_m0_rsp_payload_context,
  input  logic                    io_m1_cmd_valid,
  output logic                    io_m1_cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   io_m1_cmd_payload_address,
  input  logic                    io_m1_cmd_payload_write,
  input  logic [DATA_WIDTH-1:0]   io_m1_cmd_payload_data,
  input  logic [DATA_WIDTH/8-1:0] io_m1_cmd_payload_mask,
  input  logic [CTX_WIDTH-2:0]    io_m1_cmd_payload_context,
  output logic                    io_m1_rsp_valid,
  input  logic                    io_m1_rsp_ready,
  output logic [DATA_WIDTH-1:0]   io_m1_rsp_payload_data,
  output logic [CTX_WIDTH-2:0]    io_m1_rsp_payload_context,
  output logic                    io_bus_cmd_valid,
  input  logic                    io_bus_cmd_ready,
  output logic [ADDR_WIDTH-1:0]   io_bus_cmd_payload_address,
  output logic                    io_bus_cmd_payload_write,
  output logic [DATA_WIDTH-1:0]   io_bus_cmd_payload_data,
  output logic [DATA_WIDTH/8-1:0] io_bus_cmd_payload_mask,
  output logic [CTX_WIDTH-1:0]    io_bus_cmd_payload_context,
  input  logic                    io_bus_rsp_valid,
  output logic                    io_bus_rsp_ready,
  input  logic [DATA_WIDTH-1:0]   io_bus_rsp_payload_data,
  input  logic [CTX_WIDTH-1:0]    io_bus_rsp_payload_context,
  output logic [PW-1:0]           io_pending0,
  output logic [PW-1:0]           io_pending1,
  output logic                    io_errorUnderflow
);
  lock_state_t state_q, state_d;
  logic prio_q, prio_d, locked_id_q, locked_id_d;
  logic lock, elig0, elig1, grant, grant_en, fire, rsp_sel, rsp_fire;
  logic lim0, lim1, uf0, uf1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q == IDLE ? ((io_bus_cmd_valid && !io_bus_cmd_ready) ? LOCKED : IDLE)
                              : (io_bus_cmd_ready ? IDLE : LOCKED);
  end
  always_comb lock = state_q == LOCKED;
  always_comb begin
    elig0 = io_m0_cmd_valid && !lim0;
    elig1 = io_m1_cmd_valid && !lim1;
    grant = lock ? locked_id_q : (elig0 && elig1) ? prio_q : elig1 ? M1 : M0;
    grant_en = !reset && (lock || elig0 || elig1);
    io_bus_cmd_valid = grant_en && (grant == M1 ? io_m1_cmd_valid : io_m0_cmd_valid);
    io_bus_cmd_payload_address = grant == M1 ? io_m1_cmd_payload_address : io_m0_cmd_payload_address;
    io_bus_cmd_payload_write = grant == M1 ? io_m1_cmd_payload_write : io_m0_cmd_payload_write;
    io_bus_cmd_payload_data = grant == M1 ? io_m1_cmd_payload_data : io_m0_cmd_payload_data;
    io_bus_cmd_payload_mask = grant == M1 ? io_m1_cmd_payload_mask : io_m0_cmd_payload_mask;
    io_bus_cmd_payload_context = {grant, grant == M1 ? io_m1_cmd_payload_context : io_m0_cmd_payload_context};
    io_m0_cmd_ready = grant_en && grant == M0 && io_bus_cmd_ready;
    io_m1_cmd_ready = grant_en && grant == M1 && io_bus_cmd_ready;
    fire = io_bus_cmd_valid && io_bus_cmd_ready;
    prio_d = fire ? ~grant : prio_q;
    locked_id_d = (!lock && state_d == LOCKED) ? grant : locked_id_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_q <= M0;
      locked_id_q <= M0;
    end else begin
      prio_q <= prio_d;
      locked_id_q <= locked_id_d;
    end
  end
  // one shared response path; the source bit picks which master sees it
  always_comb begin
    rsp_sel = io_bus_rsp_payload_context[CTX_WIDTH-1];
    io_m0_rsp_valid = io_bus_rsp_valid && rsp_sel == M0;
    io_m1_rsp_valid = io_bus_rsp_valid && rsp_sel == M1;
    io_m0_rsp_payload_data = io_bus_rsp_payload_data;
    io_m1_rsp_payload_data = io_bus_rsp_payload_data;
    io_m0_rsp_payload_context = io_bus_rsp_payload_context[CTX_WIDTH-2:0];
    io_m1_rsp_payload_context = io_bus_rsp_payload_context[CTX_WIDTH-2:0];
    io_bus_rsp_ready = rsp_sel == M1 ? io_m1_rsp_ready : io_m0_rsp_ready;
    rsp_fire = io_bus_rsp_valid && io_bus_rsp_ready;
    io_errorUnderflow = uf0 || uf1;
  end
  sdram_bus_pending_counter #(.MAX_PENDING(MAX_PENDING), .PW(PW)) u_pend0 (
    .clk(clk), .reset(reset),
    .inc(fire && grant == M0), .dec(rsp_fire && rsp_sel == M0),
    .count(io_pending0), .at_limit(lim0), .underflow(uf0)
  );
  sdram_bus_pending_counter #(.MAX_PENDING(MAX_PENDING), .PW(PW)) u_pend1 (
    .clk(clk), .reset(reset),
    .inc(fire && grant == M1), .dec(rsp_fire && rsp_sel == M1),
    .count(io_pending1), .at_limit(lim1), .underflow(uf1)
  );
endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// tb_sdram_bus_arbiter: directed plan scenarios plus random traffic against a
// transaction-level model of arbitration, pending limits and response routing
module tb_sdram_bus_arbiter;
  import sdram_bus_arbiter_pkg::*;
  localparam int MAXP = 4;
  logic clk = 0, reset = 1;
  logic v[2], w[2], rr[2], cr[2], rv[2];
  logic [23:0] a[2];
  logic [15:0] d[2], rd[2];
  logic [1:0] mk[2];
  logic [6:0] c[2], rc[2];
  logic br, bv, bus_v, bus_w, brr, uf_o;
  logic [15:0] bd, bus_d;
  logic [7:0] bc, bus_ctx;
  logic [23:0] bus_a;
  logic [1:0] bus_m;
  logic [2:0] pend0_o, pend1_o;
  int checks = 0, errors = 0;
  int pend[2];
  bit prio, held, held_id, uf, racc;
  bit acc[2];
  logic [7:0] q[$];

  sdram_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .io_m0_cmd_valid(v[0]), .io_m0_cmd_ready(cr[0]), .io_m0_cmd_payload_address(a[0]),
    .io_m0_cmd_payload_write(w[0]), .io_m0_cmd_payload_data(d[0]), .io_m0_cmd_payload_mask(mk[0]),
    .io_m0_cmd_payload_context(c[0]), .io_m0_rsp_valid(rv[0]), .io_m0_rsp_ready(rr[0]),
    .io_m0_rsp_payload_data(rd[0]), .io_m0_rsp_payload_context(rc[0]),
    .io_m1_cmd_valid(v[1]), .io_m1_cmd_ready(cr[1]), .io_m1_cmd_payload_address(a[1]),
    .io_m1_cmd_payload_write(w[1]), .io_m1_cmd_payload_data(d[1]), .io_m1_cmd_payload_mask(mk[1]),
    .io_m1_cmd_payload_context(c[1]), .io_m1_rsp_valid(rv[1]), .io_m1_rsp_ready(rr[1]),
    .io_m1_rsp_payload_data(rd[1]), .io_m1_rsp_payload_context(rc[1]),
    .io_bus_cmd_valid(bus_v), .io_bus_cmd_ready(br), .io_bus_cmd_payload_address(bus_a),
    .io_bus_cmd_payload_write(bus_w), .io_bus_cmd_payload_data(bus_d), .io_bus_cmd_payload_mask(bus_m),
    .io_bus_cmd_payload_context(bus_ctx), .io_bus_rsp_valid(bv), .io_bus_rsp_ready(brr),
    .io_bus_rsp_payload_data(bd), .io_bus_rsp_payload_context(bc),
    .io_pending0(pend0_o), .io_pending1(pend1_o), .io_errorUnderflow(uf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    pend[0] = 0; pend[1] = 0; prio = 0; held = 0; held_id = 0; uf = 0;
    acc[0] = 0; acc[1] = 0; racc = 0; q.delete();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; w[i] = 0; a[i] = 0; d[i] = 0; mk[i] = 0; c[i] = 0; rr[i] = 1;
    end
    br = 1; bv = 0; bd = 0; bc = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
  endtask

  // compare one cycle of combinational outputs, then advance the model by its fires
  task automatic cycle();
    bit e0, e1, en, g, sel, fire, rfire, inc, dec;
    logic exp_bv;
    #2;
    chk("pend0", pend0_o, pend[0]);
    chk("pend1", pend1_o, pend[1]);
    chk("uflow", uf_o, uf);
    e0 = v[0] && pend[0] < MAXP;
    e1 = v[1] && pend[1] < MAXP;
    en = held || e0 || e1;
    g = held ? held_id : (e0 && e1) ? prio : e1;
    exp_bv = en && v[g];
    chk("bus_valid", bus_v, exp_bv);
    if (exp_bv) begin
      chk("bus_ctx", bus_ctx, {g, c[g]});
      chk("bus_addr", bus_a, a[g]);
      chk("bus_data", bus_d, d[g]);
      chk("bus_write", bus_w, w[g]);
      chk("bus_mask", bus_m, mk[g]);
    end
    chk("m0_ready", cr[0], en && !g && br);
    chk("m1_ready", cr[1], en && g && br);
    sel = bc[SRC_BIT];
    chk("m0_rsp_valid", rv[0], bv && !sel);
    chk("m1_rsp_valid", rv[1], bv && sel);
    chk("bus_rsp_ready", brr, rr[sel]);
    if (bv) begin
      chk("rsp_data", rd[sel], bd);
      chk("rsp_ctx", rc[sel], bc[6:0]);
    end
    fire = exp_bv && br;
    rfire = bv && rr[sel];
    if (fire) begin
      q.push_back({g, c[g]});
      prio = !g;
    end
    held = exp_bv && !br;
    held_id = g;
    for (int i = 0; i < 2; i++) begin
      inc = fire && g == i[0];
      dec = rfire && sel == i[0];
      if (dec && pend[i] == 0) uf = 1;
      if (inc && !dec) pend[i]++;
      else if (dec && !inc && pend[i] > 0) pend[i]--;
      acc[i] = inc;
    end
    racc = rfire;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    @(posedge clk); #1;
    v[0] = 1;
    #1;
    chk("rst_bus_valid", bus_v, 0);
    chk("rst_m0_ready", cr[0], 0);
    chk("rst_pend0", pend0_o, 0);
    chk("rst_uflow", uf_o, 0);
    do_reset();

    v[0] = 1; v[1] = 1; c[0] = 7'h11; c[1] = 7'h22;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cont_ctx", bus_ctx, (i % 2) ? 8'hA2 : 8'h11);
      cycle();
    end
    do_reset();

    v[0] = 1; a[0] = 24'h000010; w[0] = 1; d[0] = 16'hBEEF; mk[0] = 2'b11; c[0] = 7'h05;
    #1 chk("single_ctx", bus_ctx, 8'h05);
    cycle();
    v[0] = 0;
    chk("single_pend1", pend0_o, 1);
    bv = 1; bc = 8'h05; bd = 16'h1234;
    #1 chk("single_rsp_m0", rv[0], 1);
    chk("single_rsp_m1", rv[1], 0);
    cycle();
    bv = 0;
    chk("single_pend0", pend0_o, 0);

    v[1] = 1; c[1] = 7'h44;
    cycle();
    br = 0;
    cycle();
    v[0] = 1; c[0] = 7'h33;
    for (int i = 0; i < 3; i++) begin
      #1 chk("lock_ctx", bus_ctx, 8'hC4);
      chk("lock_m0_ready", cr[0], 0);
      cycle();
    end
    br = 1;
    cycle();
    v[1] = 0;
    #1 chk("lock_next_ctx", bus_ctx, 8'h33);
    chk("lock_next_m0_ready", cr[0], 1);
    cycle();
    do_reset();

    v[0] = 1;
    for (int i = 0; i < 4; i++) begin
      c[0] = 7'(i);
      cycle();
    end
    chk("limit_pend0", pend0_o, 4);
    v[1] = 1; c[1] = 7'h55;
    #1 chk("limit_m0_stall", cr[0], 0);
    chk("limit_m1_served", cr[1], 1);
    cycle();
    v[1] = 0;
    bv = 1; bc = 8'h00;
    #1 chk("limit_same_cycle", cr[0], 0);
    cycle();
    bv = 0;
    #1 chk("limit_next_cycle", cr[0], 1);
    cycle();
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!v[i] || acc[i]) begin
          v[i] = $urandom_range(0, 2) != 0;
          a[i] = 24'($urandom); w[i] = 1'($urandom); d[i] = 16'($urandom);
          mk[i] = 2'($urandom); c[i] = 7'($urandom);
        end
        rr[i] = $urandom_range(0, 3) != 0;
      end
      br = $urandom_range(0, 3) != 0;
      if (!bv || racc) begin
        if (q.size() > 0 && $urandom_range(0, 1) != 0) begin
          bc = q.pop_front(); bv = 1; bd = 16'($urandom);
        end else begin
          bv = 0; bc = 8'($urandom);
        end
      end
      cycle();
    end
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1; br = 1;
    for (int n = 0; n < 200 && (q.size() > 0 || (bv && !racc)); n++) begin
      if (!bv || racc) begin
        bv = q.size() > 0;
        if (bv) begin bc = q.pop_front(); bd = 16'($urandom); end
      end
      cycle();
    end
    bv = 0;
    chk("drain_pend0", pend0_o, 0);
    chk("drain_pend1", pend1_o, 0);

    v[1] = 1; c[1] = 7'h03;
    cycle();
    v[1] = 0;
    bv = 1; bc = 8'h83; bd = 16'hCAFE; rr[1] = 0; rr[0] = 1;
    for (int i = 0; i < 2; i++) begin
      #1 chk("bp_bus_rsp_ready", brr, 0);
      chk("bp_m1_rsp_valid", rv[1], 1);
      chk("bp_m1_rsp_ctx", rc[1], 7'h03);
      cycle();
    end
    rr[1] = 1;
    cycle();
    bc = 8'h00;
    cycle();
    bv = 0;
    chk("uflow_set", uf_o, 1);
    chk("uflow_pend0", pend0_o, 0);
    repeat (3) cycle();
    chk("uflow_sticky", uf_o, 1);

    v[0] = 1; c[0] = 7'h01;
    cycle();
    v[0] = 1; v[1] = 1; c[0] = 7'h02; c[1] = 7'h09; br = 0;
    cycle();
    #1 chk("arst_pre_ctx", bus_ctx, 8'h89);
    br = 1;
    reset = 1;
    #1 chk("arst_bus_valid", bus_v, 0);
    chk("arst_m1_ready", cr[1], 0);
    chk("arst_pend0", pend0_o, 0);
    chk("arst_uflow", uf_o, 0);
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    #1 chk("arst_prio", bus_ctx, 8'h02);
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
